// File: rtl/oc_bus_arbiter.sv
// Round-robin arbiter for one shared open-collector (wired-AND) line with up to four requesters.
// Optional hold timeout is enabled by defining HOLD_TIMEOUT_EN.
module oc_bus_arbiter #(
  parameter int unsigned TURN = 1
`ifdef HOLD_TIMEOUT_EN
  ,
  parameter int unsigned HOLD_MAX = 15
`endif
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [3:0] req_n,
  input  logic [3:0] d,
  output logic [3:0] grant_n,
  output logic [1:0] owner,
  output logic       busy_n,
  output logic       timeout_n,
  output logic       bus
);

  typedef enum logic [1:0] {StIdle, StGrant, StTurn} state_e;

  state_e     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] ptr_q, ptr_d;
  logic [2:0] turn_q, turn_d;
  logic [1:0] win;
  logic [3:0] elig;
  logic [3:0] mask_nxt;
  logic       any_elig;
  logic       arb;
  logic       force_rel;

`ifdef HOLD_TIMEOUT_EN
  logic [7:0] hold_q, hold_d;
  logic [3:0] mask_q;
  logic       timeout_q;

  // The grant ends after exactly HOLD_MAX cycles if the owner is still requesting.
  always_comb begin
    force_rel = (state_q == StGrant) && !req_n[owner_q] &&
                (({1'b0, hold_q} + 9'd1) == 9'(HOLD_MAX));
    hold_d = '0;
    if (state_q == StGrant && !req_n[owner_q] && !force_rel) begin
      hold_d = hold_q + 8'd1;
    end
    // A timed-out requester stays masked until it lets go of its request.
    mask_nxt = mask_q & ~req_n;
    if (force_rel) begin
      mask_nxt[owner_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      hold_q    <= '0;
      mask_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      mask_q    <= mask_nxt;
      timeout_q <= force_rel;
    end
  end

  assign timeout_n = ~timeout_q;
`else
  assign force_rel = 1'b0;
  assign mask_nxt  = '0;
  assign timeout_n = 1'b1;
`endif

  // First eligible requester at or after the pointer, wrapping modulo 4.
  always_comb begin
    elig     = ~req_n & ~mask_nxt;
    any_elig = |elig;
    win      = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      if (elig[ptr_q + 2'(k)]) begin
        win = ptr_q + 2'(k);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    turn_d  = turn_q;
    arb     = 1'b0;
    unique case (state_q)
      StIdle: arb = 1'b1;
      StGrant: begin
        if (req_n[owner_q] || force_rel) begin
          if (TURN == 0) begin
            arb = 1'b1;
          end else begin
            state_d = StTurn;
            turn_d  = 3'(TURN);
          end
        end
      end
      StTurn: begin
        turn_d = turn_q - 3'd1;
        if (turn_q <= 3'd1) begin
          arb = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (arb) begin
      if (any_elig) begin
        state_d = StGrant;
        owner_d = win;
        ptr_d   = win + 2'd1;
      end else begin
        state_d = StIdle;
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= StIdle;
      owner_q <= '0;
      ptr_q   <= '0;
      turn_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      turn_q  <= turn_d;
    end
  end

  assign grant_n = (state_q == StGrant) ? ~(4'b0001 << owner_q) : 4'b1111;
  assign busy_n  = (state_q != StGrant);
  assign owner   = owner_q;
  // Low-only driver: the pull-up lives outside this block.
  assign bus     = (state_q == StGrant && !d[owner_q]) ? 1'b0 : 1'bz;

endmodule
